// File: rtl/alu_bcd_engine_pkg.sv
// alu_pkg: opcodes, FSM state encoding and the undefined-opcode boundary shared by the ALU/BCD engine
package alu_pkg;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL, OP_SHL, OP_SHR} op_e;
  localparam int ERR_OP = 8;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_COLLECT = 3'd1;
  localparam state_t S_EXEC    = 3'd2;
  localparam state_t S_CONVERT = 3'd3;
  localparam state_t S_HOLD    = 3'd4;
endpackage

// File: rtl/alu_bcd_engine_if.sv
// alu_bcd_engine_if: serial instruction, operand and BCD result signals between producer and engine
interface alu_bcd_engine_if #(parameter int W = 6, parameter int DIGITS = 4);
  logic clear_instr, instr_bit_valid, instr_bit, result_ack;
  logic [W-1:0] a, b;
  logic busy, result_valid, sign, err;
  logic [4*DIGITS-1:0] bcd;
  modport master (output clear_instr, instr_bit_valid, instr_bit, a, b, result_ack,
                  input busy, result_valid, bcd, sign, err);
  modport slave (input clear_instr, instr_bit_valid, instr_bit, a, b, result_ack,
                 output busy, result_valid, bcd, sign, err);
endinterface

// File: rtl/alu_bcd_engine_dd_conv.sv
// alu_dd_conv: sequential shift-add-3 binary to BCD converter, one input bit per cycle
module alu_dd_conv #(parameter int N = 12, parameter int DIGITS = 4) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N-1:0]          bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int CW = $clog2(N + 1);
  logic [N-1:0] sr;
  logic [CW-1:0] cnt;
  logic run;
  logic [4*DIGITS-1:0] adj;
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = adj[4*i +: 4] >= 4'd5 ? adj[4*i +: 4] + 4'd3 : adj[4*i +: 4];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sr   <= '0;
      bcd  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sr  <= bin;
        bcd <= '0;
        cnt <= CW'(N);
        run <= 1'b1;
      end else if (run) begin
        sr  <= sr << 1;
        bcd <= {adj[4*DIGITS-2:0], sr[N-1]};
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/alu_bcd_engine.sv
// alu_bcd_engine: serial-opcode ALU whose 2W-bit result is presented as packed BCD.
// Define SIGNED_MODE_EN to report SUB as sign plus magnitude instead of a wrapped value.
module alu_bcd_engine import alu_pkg::*; #(
  parameter int W      = 6,
  parameter int OPW    = 4,
  parameter int DIGITS = 4
) (
  input logic clk,
  input logic reset_all,
  alu_bcd_engine_if.slave bus
);
  localparam int CW = $clog2(OPW + 1);
  localparam int SW = $clog2(W);
  state_t state;
  logic [CW-1:0] cnt;
  logic [OPW-1:0] opsh, opcode;
  logic [W-1:0] a_r, b_r;
  logic [2*W-1:0] ax, bx, r;
  logic [SW-1:0] sh;
  logic neg, bad, done, rv, sign_r, err_r;
  logic [4*DIGITS-1:0] conv_bcd, bcd_r;
  op_e op;
  always_comb begin
    op  = op_e'(opcode[2:0]);
    bad = int'(opcode) >= ERR_OP;
    ax  = {{W{1'b0}}, a_r};
    bx  = {{W{1'b0}}, b_r};
    sh  = b_r[SW-1:0];
    neg = 1'b0;
`ifdef SIGNED_MODE_EN
    neg = !bad && op == OP_SUB && a_r < b_r;
`endif
    r = bad ? '0 :
        op == OP_ADD ? ax + bx :
        op == OP_SUB ? (neg ? bx - ax : ax - bx) :
        op == OP_AND ? ax & bx :
        op == OP_OR  ? ax | bx :
        op == OP_XOR ? ax ^ bx :
        op == OP_MUL ? ax * bx :
        op == OP_SHL ? ax << sh : ax >> sh;
  end
  // clear_instr also aborts a conversion in flight so no stale done can surface
  alu_dd_conv #(.N(2*W), .DIGITS(DIGITS)) u_conv (
    .clk(clk), .rst(reset_all | bus.clear_instr), .start(state == S_EXEC),
    .bin(r), .done(done), .bcd(conv_bcd)
  );
  always_ff @(posedge clk) begin
    if (reset_all) begin
      state  <= S_IDLE;
      cnt    <= '0;
      opsh   <= '0;
      opcode <= OPW'(3);
      a_r    <= '0;
      b_r    <= '0;
      rv     <= 1'b0;
      bcd_r  <= '0;
      sign_r <= 1'b0;
      err_r  <= 1'b0;
    end else if (bus.clear_instr || (state == S_HOLD && bus.result_ack)) begin
      state  <= S_IDLE;
      cnt    <= '0;
      rv     <= 1'b0;
      bcd_r  <= '0;
      sign_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_COLLECT: if (bus.instr_bit_valid) begin
          opsh <= {opsh[OPW-2:0], bus.instr_bit};
          if (cnt == CW'(OPW - 1)) begin
            opcode <= {opsh[OPW-2:0], bus.instr_bit};
            a_r    <= bus.a;
            b_r    <= bus.b;
            cnt    <= '0;
            state  <= S_EXEC;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= S_COLLECT;
          end
        end
        S_EXEC: begin
          err_r  <= bad;
          sign_r <= neg;
          state  <= S_CONVERT;
        end
        S_CONVERT: if (done) begin
          bcd_r <= conv_bcd;
          rv    <= 1'b1;
          state <= S_HOLD;
        end
        S_HOLD: state <= S_HOLD;
        default: state <= S_IDLE;
      endcase
    end
  end
  assign bus.busy         = state != S_IDLE;
  assign bus.result_valid = rv;
  assign bus.bcd          = bcd_r;
  assign bus.sign         = sign_r;
  assign bus.err          = err_r;
endmodule

// File: tb/tb_alu_bcd_engine.sv
// tb_alu_bcd_engine: directed vectors with hand-computed BCD results for alu_bcd_engine
module tb_alu_bcd_engine;
  logic clk = 1'b0;
  logic reset_all = 1'b1;
  int errors = 0;
  int checks = 0;
  int n;
  logic seen;
  logic [15:0] held;
  alu_bcd_engine_if #(.W(6), .DIGITS(4)) bus ();
  alu_bcd_engine #(.W(6), .OPW(4), .DIGITS(4)) dut (.clk(clk), .reset_all(reset_all), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [3:0] op, input logic [5:0] av, input logic [5:0] bv);
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk);
      bus.result_ack = 1'b0;
      bus.instr_bit_valid = 1'b1;
      bus.instr_bit = op[i];
      bus.a = av;
      bus.b = bv;
    end
    @(negedge clk);
    bus.instr_bit_valid = 1'b0;
  endtask
  task automatic wait_rv(output int cyc);
    cyc = 0;
    while (!bus.result_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask
  task automatic ack();
    @(negedge clk);
    bus.result_ack = 1'b1;
    @(negedge clk);
    bus.result_ack = 1'b0;
  endtask
  task automatic watch(input int cyc, output logic s);
    s = 1'b0;
    repeat (cyc) begin
      @(negedge clk);
      s |= bus.result_valid;
    end
  endtask
  initial begin
    bus.clear_instr = 1'b0;
    bus.instr_bit_valid = 1'b0;
    bus.instr_bit = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.result_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset_all = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_rv", bus.result_valid, 0);
    check("rst_bcd", bus.bcd, 16'h0000);
    check("rst_sign", bus.sign, 0);
    check("rst_err", bus.err, 0);
    send(4'd0, 6'd63, 6'd63);
    wait_rv(n);
    check("add_latency", n, 14);
    check("add_bcd", bus.bcd, 16'h0126);
    check("add_err", bus.err, 0);
    check("add_busy", bus.busy, 1);
    ack();
    check("ack_rv", bus.result_valid, 0);
    check("ack_busy", bus.busy, 0);
    check("ack_bcd", bus.bcd, 16'h0000);
    send(4'd5, 6'd63, 6'd63);
    wait_rv(n);
    check("mul_bcd", bus.bcd, 16'h3969);
    held = bus.bcd;
    repeat (5) @(negedge clk);
    check("mul_hold_rv", bus.result_valid, 1);
    check("mul_hold_bcd", bus.bcd, held);
    ack();
    send(4'd1, 6'd5, 6'd9);
    ack();
    wait_rv(n);
    check("sub_latency_after_stray_ack", n, 12);
`ifdef SIGNED_MODE_EN
    check("sub_sign", bus.sign, 1);
    check("sub_bcd", bus.bcd, 16'h0004);
`else
    check("sub_sign", bus.sign, 0);
    check("sub_bcd", bus.bcd, 16'h4092);
`endif
    ack();
    send(4'd12, 6'd7, 6'd3);
    wait_rv(n);
    check("undef_err", bus.err, 1);
    check("undef_bcd", bus.bcd, 16'h0000);
    ack();
    check("undef_err_cleared", bus.err, 0);
    send(4'd4, 6'd5, 6'd9);
    repeat (6) @(negedge clk);
    check("clr_busy_before", bus.busy, 1);
    bus.clear_instr = 1'b1;
    @(negedge clk);
    bus.clear_instr = 1'b0;
    check("clr_busy", bus.busy, 0);
    watch(20, seen);
    check("clr_no_rv", seen, 0);
    @(negedge clk);
    bus.clear_instr = 1'b1;
    bus.instr_bit_valid = 1'b1;
    bus.instr_bit = 1'b1;
    @(negedge clk);
    bus.clear_instr = 1'b0;
    bus.instr_bit_valid = 1'b0;
    send(4'd0, 6'd1, 6'd2);
    wait_rv(n);
    check("clr_bit_latency", n, 14);
    check("clr_bit_bcd", bus.bcd, 16'h0003);
    ack();
    send(4'd2, 6'd45, 6'd27);
    wait_rv(n);
    check("and_bcd", bus.bcd, 16'h0009);
    @(negedge clk);
    bus.result_ack = 1'b1;
    send(4'd6, 6'd5, 6'd3);
    wait_rv(n);
    check("b2b_shl_latency", n, 14);
    check("b2b_shl_bcd", bus.bcd, 16'h0040);
    @(negedge clk);
    bus.result_ack = 1'b1;
    send(4'd7, 6'd48, 6'd4);
    wait_rv(n);
    check("b2b_shr_bcd", bus.bcd, 16'h0003);
    ack();
    send(4'd3, 6'd5, 6'd9);
    wait_rv(n);
    check("or_bcd", bus.bcd, 16'h0013);
    check("or_sign", bus.sign, 0);
    @(negedge clk);
    reset_all = 1'b1;
    @(negedge clk);
    reset_all = 1'b0;
    check("hold_rst_rv", bus.result_valid, 0);
    check("hold_rst_busy", bus.busy, 0);
    check("hold_rst_bcd", bus.bcd, 16'h0000);
    watch(20, seen);
    check("hold_rst_no_rv", seen, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_bcd_engine.md
ALU_BCD_ENGINE -- requirements
Module: alu_bcd_engine

Interface
REQ-001 Parameter W, default 6, operand width in bits (>= 2).
REQ-002 Parameter OPW, default 4, opcode width in bits.
REQ-003 Parameter DIGITS, default 4, BCD output digits; SHALL satisfy 10^DIGITS > 2^(2W).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset_all  in  1  reset, synchronous, active-high.
REQ-006 clear_instr  in  1  synchronous abort of the current instruction; operands kept.
REQ-007 instr_bit_valid  in  1  qualifies instr_bit for one cycle.
REQ-008 instr_bit  in  1  serial opcode bit, MSB first.
REQ-009 A, B  in  W each  operands, sampled on the final opcode bit.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 result_valid  out  1  bcd/sign/err valid; held until acknowledged.
REQ-012 result_ack  in  1  consumer accept; effective only while result_valid=1.
REQ-013 bcd  out  4*DIGITS  packed BCD result, digit 0 in bits [3:0].
REQ-014 sign  out  1  result negative (SIGNED_MODE_EN only).
REQ-015 err  out  1  undefined opcode executed.

Function
REQ-016 FSM states: IDLE, COLLECT, EXEC, CONVERT, HOLD.
REQ-017 IDLE -> COLLECT on first instr_bit_valid; bit counter counts accepted bits.
REQ-018 On the OPW-th accepted bit: opcode, A and B registered; next state EXEC.
REQ-019 instr_bit_valid ignored in EXEC, CONVERT and HOLD.
REQ-020 EXEC lasts one cycle; computes a 2W-bit result R: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 MUL, 6 SHL (A<<B[log2 W-1:0]), 7 SHR (logical).
REQ-021 Opcodes 8 to 2^OPW-1: R=0, err=1; all others err=0.
REQ-022 Logic ops zero-extend to 2W bits; ADD/SUB computed in 2W bits, unsigned wrap unless REQ-036.
REQ-023 CONVERT runs shift-add-3 double-dabble for exactly 2W cycles, one bit per cycle.
REQ-024 Latency: final opcode bit at edge t -> result_valid high from edge t+2+2W.
REQ-025 HOLD: result_valid=1, bcd/sign/err stable; result_ack=1 -> IDLE next cycle, result_valid=0.
REQ-026 result_ack while result_valid=0 has no effect.
REQ-027 clear_instr in any state -> IDLE next cycle; bit counter, bcd, sign, err, result_valid cleared; A/B registers retained.
REQ-028 clear_instr coincident with instr_bit_valid: clear wins, bit discarded.
REQ-029 clear_instr coincident with result_ack in HOLD: same result as ack (IDLE, outputs cleared).
REQ-030 Back-to-back: a bit presented in the cycle after ack is accepted (IDLE).

Reset
REQ-031 reset_all overrides clear_instr and all other inputs.
REQ-032 After reset: state IDLE, busy=0, result_valid=0, bcd=0, sign=0, err=0, bit counter=0.
REQ-033 After reset: A/B registers=0, opcode register=3 (OR).
REQ-034 Reset during CONVERT or HOLD discards the result; no result_valid pulse follows.

Configuration
REQ-035 Macro SIGNED_MODE_EN selects signed SUB handling.
REQ-036 Defined: SUB with A<B gives sign=1 and bcd = |A-B|; other ops sign=0.
REQ-037 Undefined: sign tied 0; SUB wraps modulo 2^(2W) and the wrapped value is converted.

Structure
REQ-038 Shared package alu_pkg holds the opcode enumeration, FSM state typedef and the ERR/undefined-opcode boundary constant.
REQ-039 The double-dabble converter SHALL be one sub-module, alu_dd_conv (start, 2W-bit binary in, done, DIGITS-digit BCD out).

Verification (W=6, OPW=4, DIGITS=4)
REQ-040 Reset, then idle 10 cycles -> busy=0, result_valid=0, bcd=0x0000.
REQ-041 Opcode 0, A=63, B=63 -> bcd=0x0126, err=0; result_valid exactly 14 cycles after the last bit.
REQ-042 Opcode 5, A=63, B=63 -> bcd=0x3969; hold 5 cycles without ack -> bcd stable, result_valid=1.
REQ-043 Opcode 1, A=5, B=9 -> with SIGNED_MODE_EN: sign=1, bcd=0x0004; without: sign=0, bcd=0x4092.
REQ-044 Opcode 12 -> err=1, bcd=0x0000; clear_instr asserted mid-CONVERT of another op -> IDLE next cycle, no result_valid.
REQ-045 Two instructions back-to-back, ack and next bit on consecutive cycles -> both results correct, no bits lost.
